tick_to_level_gen: RTL and testbench
====================================

Name: tick_to_level_gen

Overview:
- Inverse of the rising-edge detector: converts single-cycle tick pulses back into a clean level waveform.
- Each accepted tick produces a high pulse of exactly HIGH_CYCLES clocks, followed by a guaranteed low guard of LOW_CYCLES clocks.
- A downstream edge detector therefore sees exactly one rising edge per accepted tick.
- Sits between the event logic and any level-sensitive consumer or edge detector.

Parameters:
- HIGH_CYCLES, default 4: clocks `level` is held high per accepted tick. Must be ≥1.
- LOW_CYCLES, default 2: minimum clocks `level` is held low after each high pulse. Must be ≥1.
- CNT_W, default 8: width of the internal dwell counter and of `pulse_cnt`. Must hold max(HIGH_CYCLES, LOW_CYCLES).
- RETRIGGER, default 0: 1 = a tick during HIGH extends the pulse; 0 = that tick is dropped.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick  in  1  single-cycle request pulse, synchronous to clk.
- level  out  1  registered level output.
- busy  out  1  registered; high whenever state ≠ IDLE.
- drop  out  1  registered one-cycle pulse; a tick was discarded.
- pulse_cnt  out  CNT_W  count of high pulses started; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, async): state=IDLE, level=0, busy=0, drop=0, pending=0, dwell counter=0, pulse_cnt=0.
- All outputs are registered (Moore). A reset asserted mid-pulse forces level=0 immediately and discards pending.
- FSM states: IDLE, HIGH, GUARD.
- IDLE:
  - On tick, next cycle: state=HIGH, level=1, counter=HIGH_CYCLES-1, pulse_cnt+1.
  - Latency tick→level is 1 clock.
- HIGH:
  - level=1. Counter decrements each clock.
  - At counter=0, next cycle: state=GUARD, level=0, counter=LOW_CYCLES-1.
  - Tick in HIGH, RETRIGGER=1: counter reloads to HIGH_CYCLES-1. No new edge, pulse_cnt unchanged. The reload takes priority over the counter=0 exit.
  - Tick in HIGH, RETRIGGER=0: drop=1 on the next cycle. Pulse length unchanged.
- GUARD:
  - level=0. Counter decrements each clock.
  - A tick sets `pending` (one-deep).
  - A tick while pending is already 1 → drop=1 next cycle.
  - At counter=0: if pending (or a tick arrives in that same cycle), next state=HIGH with the same loads as from IDLE, and pending clears. Otherwise next state=IDLE.
- Simultaneous events:
  - Tick on the last GUARD cycle counts as pending and is consumed; there is no gap cycle.
  - Tick on the last HIGH cycle with RETRIGGER=0 is dropped, not queued.
- `drop` is high for exactly one cycle per discarded tick. Back-to-back discarded ticks give back-to-back drop cycles.
- `pulse_cnt` wraps from 2^CNT_W-1 to 0 with no flag.
- Default case of the FSM: return to IDLE with level=0.

Decomposition:
- Shared package `level_gen_pkg`:
  - state encoding localparams IDLE=2'd0, HIGH=2'd1, GUARD=2'd2;
  - default HIGH_CYCLES/LOW_CYCLES constants shared with the edge-detector bench.
- One natural sub-module: `dwell_counter`, a loadable down-counter with load, value, and a zero flag. It is used for both HIGH and GUARD timing.
- The FSM, pending flag and output registers stay in the top module.

Test Plan:
- Defaults; reset released; tick at cycle 0 → level=1 on cycles 1-4, 0 on cycles 5-6; busy=1 on cycles 1-6; busy=0 and state IDLE at cycle 7; pulse_cnt=1.
- Tick at cycle 0, second tick at cycle 5 (GUARD) → pending set; level=1 on cycles 7-10 with no gap after guard; pulse_cnt=2; drop never asserted.
- RETRIGGER=0: ticks at cycles 0 and 2 → level high cycles 1-4 only; drop=1 on cycle 3 only; pulse_cnt=1.
- RETRIGGER=1: ticks at cycles 0 and 3 → level high cycles 1-7 continuously; one rising edge into an attached rising_edge_detector; pulse_cnt=1.
- GUARD double tick: ticks at 0, 5, 6 → second guard tick dropped (drop=1 at cycle 7); one follow-up pulse on cycles 7-10.
- Reset pulled low at cycle 2 mid-HIGH → level=0, busy=0, pulse_cnt=0 asynchronously. After release, a tick gives a full 4-cycle pulse; CNT_W=2 run of 5 pulses ends with pulse_cnt=1 (wrap).

Source files
------------

// File: rtl/level_gen_pkg.sv
// level_gen_pkg: state encoding and default dwell lengths for the tick-to-level generator.
package level_gen_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GUARD = 2'd2} state_t;
    localparam int DEF_HIGH_CYCLES = 4;
    localparam int DEF_LOW_CYCLES  = 2;
endpackage

// File: rtl/tick_to_level_gen_dwell_counter.sv
// dwell_counter: loadable down-counter that parks at zero and flags it.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_value;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_value <= '0;
        else if (i_load) r_value <= i_value;
        else if (r_value != '0) r_value <= r_value - 1'b1;
    end
    assign o_zero = (r_value == '0);
endmodule

// File: rtl/tick_to_level_gen.sv
// tick_to_level_gen: turns single-cycle ticks into HIGH_CYCLES-long level pulses,
// each followed by a LOW_CYCLES guard so every accepted tick yields one rising edge.
module tick_to_level_gen
    import level_gen_pkg::*;
#(
    parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
    parameter int CNT_W       = 8,
    parameter int RETRIGGER   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    output logic             o_level,
    output logic             o_busy,
    output logic             o_drop,
    output logic [CNT_W-1:0] o_pulse_cnt
);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    state_t           r_state, w_next;
    logic             r_pending, w_pending;
    logic             r_level, r_busy, r_drop;
    logic [CNT_W-1:0] r_pulse_cnt;
    logic             w_load, w_drop, w_start, w_zero;
    logic [CNT_W-1:0] w_load_val;
    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (w_load),
        .i_value(w_load_val),
        .o_zero (w_zero)
    );
    always_comb begin
        w_next     = r_state;
        w_pending  = r_pending;
        w_load     = 1'b0;
        w_load_val = HIGH_LOAD;
        w_drop     = 1'b0;
        w_start    = 1'b0;
        case (r_state)
            IDLE: begin
                w_next  = i_tick ? HIGH : IDLE;
                w_load  = i_tick;
                w_start = i_tick;
            end
            HIGH: begin
                // a retrigger reload wins over the end-of-pulse exit
                if (i_tick && RETRIGGER != 0) begin
                    w_load = 1'b1;
                end else begin
                    w_drop = i_tick;
                    if (w_zero) begin
                        w_next     = GUARD;
                        w_load     = 1'b1;
                        w_load_val = LOW_LOAD;
                    end
                end
            end
            GUARD: begin
                w_drop = i_tick && r_pending;
                if (w_zero) begin
                    w_pending = 1'b0;
                    w_next    = (r_pending || i_tick) ? HIGH : IDLE;
                    w_load    = r_pending || i_tick;
                    w_start   = r_pending || i_tick;
                end else begin
                    w_pending = r_pending || i_tick;
                end
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_level     <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_pending   <= w_pending;
            r_level     <= (w_next == HIGH);
            r_busy      <= (w_next != IDLE);
            r_drop      <= w_drop;
            r_pulse_cnt <= r_pulse_cnt + CNT_W'(w_start);
        end
    end
    assign o_level     = r_level;
    assign o_busy      = r_busy;
    assign o_drop      = r_drop;
    assign o_pulse_cnt = r_pulse_cnt;
endmodule

// File: tb/tb_tick_to_level_gen.sv
// tb_tick_to_level_gen: three generator variants (RETRIGGER=0, RETRIGGER=1, CNT_W=2)
// driven by one tick stream and checked per cycle against a timeline model.
module tb_tick_to_level_gen;
    import level_gen_pkg::*;
    localparam int H = DEF_HIGH_CYCLES;
    localparam int L = DEF_LOW_CYCLES;

    typedef struct {
        int t;
        int d;
        bit lvl;
        bit bsy;
        bit drp;
        int pc;
    } exp_t;

    logic       clk = 0;
    logic       rst_n;
    logic       tick;
    logic [2:0] lvl, bsy, drp;
    logic [7:0] pc0, pc1;
    logic [1:0] pc2;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       q[$];

    // timeline model: start of high, last high cycle, last guard cycle
    int hs[3], he[3], le[3], cnt[3];
    bit pend[3];
    int rt[3]   = '{0, 1, 0};
    int mask[3] = '{255, 255, 3};

    tick_to_level_gen #(.RETRIGGER(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick),
        .o_level(lvl[0]), .o_busy(bsy[0]), .o_drop(drp[0]), .o_pulse_cnt(pc0));
    tick_to_level_gen #(.RETRIGGER(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick),
        .o_level(lvl[1]), .o_busy(bsy[1]), .o_drop(drp[1]), .o_pulse_cnt(pc1));
    tick_to_level_gen #(.CNT_W(2), .RETRIGGER(0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick),
        .o_level(lvl[2]), .o_busy(bsy[2]), .o_drop(drp[2]), .o_pulse_cnt(pc2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pc_of(input int d);
        return d == 0 ? int'(pc0) : d == 1 ? int'(pc1) : int'(pc2);
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            hs[d] = 0; he[d] = -1; le[d] = -1; cnt[d] = 0; pend[d] = 0;
        end
    endtask

    task automatic start(input int d, input int n);
        hs[d] = n + 1; he[d] = n + H; le[d] = n + H + L; cnt[d]++;
    endtask

    // tick applied during cycle n; expected outputs become visible in cycle n+1
    task automatic model(input int d, input int n, input bit tk);
        exp_t e;
        bit dr = 0;
        if (tk) begin
            if (n > le[d]) start(d, n);
            else if (n <= he[d]) begin
                if (rt[d] != 0) begin he[d] = n + H; le[d] = n + H + L; end
                else dr = 1;
            end else if (pend[d]) dr = 1;
            else pend[d] = 1;
        end
        if (n == le[d] && pend[d]) begin
            pend[d] = 0;
            start(d, n);
        end
        e.t = n + 1; e.d = d;
        e.lvl = (n + 1 >= hs[d]) && (n + 1 <= he[d]);
        e.bsy = (n + 1 >= hs[d]) && (n + 1 <= le[d]);
        e.drp = dr;
        e.pc  = cnt[d] & mask[d];
        q.push_back(e);
    endtask

    task automatic step(input bit tk);
        @(posedge clk);
        #1;
        tick = tk;
        for (int d = 0; d < 3; d++) model(d, cyc, tk);
    endtask

    task automatic seq(input logic [31:0] pat, input int len);
        for (int i = 0; i < len; i++) step(pat[i]);
    endtask

    task automatic chk_reset_outputs(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_level"}, d, int'(lvl[d]), 0);
            chk({nm, "_busy"}, d, int'(bsy[d]), 0);
            chk({nm, "_drop"}, d, int'(drp[d]), 0);
            chk({nm, "_cnt"}, d, pc_of(d), 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].t <= cyc) begin
                automatic exp_t e = q.pop_front();
                if (e.t < cyc) chk("stale_entry", e.d, e.t, cyc);
                else begin
                    chk("level", e.d, int'(lvl[e.d]), int'(e.lvl));
                    chk("busy", e.d, int'(bsy[e.d]), int'(e.bsy));
                    chk("drop", e.d, int'(drp[e.d]), int'(e.drp));
                    chk("pulse_cnt", e.d, pc_of(e.d), e.pc);
                end
            end
        end
    end

    initial begin
        rst_n = 0;
        tick  = 0;
        model_reset();
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #3 rst_n = 1;
        seq(32'h0000_0001, 12);              // single pulse
        seq(32'h0000_0021, 16);              // tick in guard -> pending
        seq(32'h0000_0005, 12);              // tick mid-high
        seq(32'h0000_0009, 14);              // retrigger window
        seq(32'h0000_0061, 16);              // double guard tick
        seq(32'h0000_0011, 14);              // tick on last high cycle
        seq(32'h0000_0041, 16);              // tick on last guard cycle
        seq(32'h0000_0001, 3);
        @(posedge clk);
        #3 rst_n = 0;
        tick = 0;
        #1;
        chk_reset_outputs("async_reset");
        q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1;
        seq(32'h0000_0001, 10);              // full pulse after reset
        for (int i = 0; i < 5; i++) seq(32'h0000_0001, 7);  // wraps the 2-bit counter
        for (int i = 0; i < 800; i++) step($urandom_range(0, 2) == 0);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 7) == 0);
        seq(32'h0, 12);
        @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) chk("queue_drain", 0, q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
